// File: rtl/ad1_avg_decim.sv
// ad1_avg_decim: edge-detects PmodAD1 samples, boxcar-averages 2**AVG_LOG2 per channel, valid/ready output with sticky overrun
module ad1_avg_decim #(
  parameter int AVG_LOG2  = 2,
  parameter int DATA_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 drdy,
  input  logic [15:0]          din0,
  input  logic [15:0]          din1,
  input  logic                 enable,
  input  logic                 ovr_clr,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data0,
  output logic [DATA_BITS-1:0] m_data1,
  output logic                 overrun
);
  localparam int AW = DATA_BITS + AVG_LOG2;
  localparam int CW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);
  typedef enum logic {S_IDLE, S_ACCUM} state_t;
  state_t state;
  logic drdy_q, strobe, done;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc0, acc1, sum0, sum1;
  logic [DATA_BITS-1:0] res0, res1;
  logic unused;
  always_comb begin
    strobe = drdy & ~drdy_q;
    done = (state == S_ACCUM) & enable & strobe & (cnt == LAST);
    sum0 = acc0 + AW'(din0[DATA_BITS-1:0]);
    sum1 = acc1 + AW'(din1[DATA_BITS-1:0]);
    res0 = DATA_BITS'(sum0 >> AVG_LOG2);
    res1 = DATA_BITS'(sum1 >> AVG_LOG2);
    unused = &{1'b0, din0, din1};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      drdy_q  <= 1'b0;
      acc0    <= '0;
      acc1    <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
      m_data0 <= '0;
      m_data1 <= '0;
      overrun <= 1'b0;
    end else begin
      drdy_q <= drdy;
      if (state == S_IDLE || !enable) begin
        state <= enable ? S_ACCUM : S_IDLE;
        acc0  <= '0;
        acc1  <= '0;
        cnt   <= '0;
      end else if (strobe) begin
        acc0 <= done ? '0 : sum0;
        acc1 <= done ? '0 : sum1;
        cnt  <= done ? '0 : cnt + 1'b1;
      end
      // A new result may replace a pair only when that pair is leaving this cycle
      if (done && (!m_valid || m_ready)) begin
        m_valid <= 1'b1;
        m_data0 <= res0;
        m_data1 <= res1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      overrun <= (done & m_valid & ~m_ready) | (overrun & ~ovr_clr);
    end
  end
endmodule
